receive_packet: RTL and testbench
=================================

// Module: receive_packet
// PURPOSE
//  UART-side packet receiver, the far end of the send_packet link: deserialises 8N1 bytes on rx,
//  hunts for a sync byte and assembles a 10-word payload (word0 = timestamp, words1-9 = data).
//  Validates an XOR checksum, then presents the whole packet on a flat bus with a 1-cycle valid.
//  Sits at the ground/host end of the telemetry link; consumer logic samples pkt_data on pkt_valid.
// PARAMETERS
//  CLKS_PER_BIT  434          clk cycles per UART bit (50 MHz / 115200 baud)
//  NUM_WORDS     10           32-bit words per packet (timestamp + 9 data)
//  SYNC_BYTE     8'hA5        frame-start marker
//  TIMEOUT_BITS  20           max idle bit-times between bytes inside a packet before abort
// PORTS
//  clk        in   1              system clock
//  rst_n      in   1              async active-low reset
//  rx         in   1              UART serial input, idle high, async to clk
//  pkt_data   out  NUM_WORDS*32   word k at [32k+31:32k]; word0 = timestamp
//  pkt_valid  out  1              1-cycle pulse: pkt_data updated with a good packet
//  pkt_err    out  1              1-cycle pulse: checksum mismatch, packet dropped
//  frame_err  out  1              1-cycle pulse: stop bit low or inter-byte timeout
//  isbusy     out  1              high from sync byte accepted until packet end/abort
// BEHAVIOUR
//  Reset: all outputs 0; pkt_data 0; FSM -> HUNT; byte receiver -> IDLE.
//  Input: rx through 2-FF synchroniser (reset value 1); all decisions use synced value.
//  Byte RX (8N1, LSB first): IDLE waits for falling edge; START re-samples at CLKS_PER_BIT/2,
//   returns to IDLE if high (glitch); DATA samples 8 bits each CLKS_PER_BIT later; STOP samples
//   once: 1 -> byte_done strobe; 0 -> byte discarded, frame_err pulse, back to IDLE.
//  Packet FSM: HUNT -> PAYLOAD on byte == SYNC_BYTE (other bytes silently ignored);
//   PAYLOAD collects NUM_WORDS*4 bytes, big-endian per word, word0 first; running XOR of payload
//   bytes (seed 8'h00); CHECK takes next byte as checksum.
//   CHECK match -> pkt_data loaded, pkt_valid pulse the cycle after checksum byte_done; -> HUNT.
//   CHECK mismatch -> pkt_err pulse, pkt_data unchanged; -> HUNT.
//  pkt_data only changes on a good packet; partial words never visible.
//  SYNC_BYTE value inside PAYLOAD/CHECK is ordinary data (no resync).
//  Timeout: in PAYLOAD/CHECK, counter of clk since last byte_done; reaching TIMEOUT_BITS*
//   CLKS_PER_BIT -> frame_err pulse, -> HUNT. Counter cleared on each byte_done.
//  Stop-bit error inside PAYLOAD/CHECK also aborts packet -> HUNT.
//  isbusy: set on clk after sync byte_done, cleared same cycle as pkt_valid/pkt_err/abort.
//  pkt_valid, pkt_err, frame_err mutually exclusive per cycle; never held >1 cycle.
//  Reset mid-packet: immediate abort, no pulses, pkt_data cleared.
//  Latency: stop-bit sample of checksum byte -> pkt_valid = 1 cycle after byte_done.
// TESTING
//  1 Send A5, words 00024543,00001254,00007689,00004245,00007764,00002413,78766536,00008038,
//    00005632,00000000 big-endian, correct XOR -> one pkt_valid, pkt_data words exact, isbusy drops.
//  2 Same packet, checksum byte XOR 8'h01 -> pkt_err pulse, no pkt_valid, pkt_data still 0.
//  3 Noise bytes 00,FF,5A before A5, then good packet -> only that packet reported.
//  4 Stall after 17 payload bytes > TIMEOUT_BITS bit-times -> frame_err, isbusy 0; next good
//    packet received correctly.
//  5 Byte with stop bit forced low mid-payload -> frame_err, packet dropped, FSM in HUNT.
//  6 Assert rst_n=0 mid-payload -> outputs 0 immediately; after release good packet accepted.

Source files
------------

// File: rtl/receive_packet.sv
// receive_packet: 8N1 UART receiver with sync-byte framing, XOR checksum
// validation and a flat packet output bus updated only on good packets.
module receive_packet #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          NUM_WORDS    = 10,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx,
  output logic [NUM_WORDS*32-1:0] pkt_data,
  output logic                   pkt_valid,
  output logic                   pkt_err,
  output logic                   frame_err,
  output logic                   isbusy
);

  localparam int NB       = NUM_WORDS * 4;
  localparam int BW       = $clog2(NB);
  localparam int PW       = $clog2(NUM_WORDS * 32);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {ST_HUNT, ST_PAYLOAD, ST_CHECK} pkt_state_t;

  // Running checksum update: XOR of every payload byte
  function automatic logic [7:0] cks_next(input logic [7:0] cks, input logic [7:0] b);
    return cks ^ b;
  endfunction

  logic            rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t       rx_state_r;
  logic [15:0]     baud_cnt_r;
  logic [2:0]      bit_idx_r;
  logic [7:0]      shift_r;
  logic [7:0]      rx_byte_r;
  logic            byte_done_r;
  logic            stop_err_r;

  pkt_state_t               state_r;
  logic [BW-1:0]            byte_cnt_r;
  logic [7:0]               cks_r;
  logic [31:0]              to_cnt_r;
  logic [NUM_WORDS*32-1:0]  buf_r;
  logic [PW-1:0]            byte_pos_s;

  // Big-endian byte placement: word byte_cnt/4, most significant byte first
  assign byte_pos_s = PW'({byte_cnt_r[BW-1:2], 5'd0}) + PW'({~byte_cnt_r[1:0], 3'd0});

  // Two-flop synchroniser for the asynchronous rx line, plus edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Byte receiver: start detect, mid-bit sampling, stop-bit validation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r  <= RX_IDLE;
      baud_cnt_r  <= 16'd0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'd0;
      rx_byte_r   <= 8'd0;
      byte_done_r <= 1'b0;
      stop_err_r  <= 1'b0;
    end else begin
      byte_done_r <= 1'b0;
      stop_err_r  <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          baud_cnt_r <= 16'd0;
          bit_idx_r  <= 3'd0;
          if (rx_prev_r && !rx_sync_r) begin
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (baud_cnt_r == 16'(CLKS_PER_BIT / 2 - 1)) begin
            baud_cnt_r <= 16'd0;
            // A start bit that is high again at mid-bit was only a glitch
            rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        RX_DATA: begin
          if (baud_cnt_r == 16'(CLKS_PER_BIT - 1)) begin
            baud_cnt_r <= 16'd0;
            shift_r    <= {rx_sync_r, shift_r[7:1]};
            bit_idx_r  <= bit_idx_r + 3'd1;
            if (bit_idx_r == 3'd7) begin
              rx_state_r <= RX_STOP;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        RX_STOP: begin
          if (baud_cnt_r == 16'(CLKS_PER_BIT - 1)) begin
            baud_cnt_r <= 16'd0;
            rx_state_r <= RX_IDLE;
            if (rx_sync_r) begin
              rx_byte_r   <= shift_r;
              byte_done_r <= 1'b1;
            end else begin
              stop_err_r  <= 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        default: rx_state_r <= RX_IDLE;
      endcase
    end
  end

  // Packet FSM: sync hunt, payload assembly, checksum check, timeout/abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_HUNT;
      byte_cnt_r <= '0;
      cks_r      <= 8'd0;
      to_cnt_r   <= 32'd0;
      buf_r      <= '0;
      pkt_data   <= '0;
      pkt_valid  <= 1'b0;
      pkt_err    <= 1'b0;
      frame_err  <= 1'b0;
      isbusy     <= 1'b0;
    end else begin
      pkt_valid <= 1'b0;
      pkt_err   <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        ST_HUNT: begin
          to_cnt_r <= 32'd0;
          if (stop_err_r) begin
            frame_err <= 1'b1;
          end else if (byte_done_r && (rx_byte_r == SYNC_BYTE)) begin
            state_r    <= ST_PAYLOAD;
            isbusy     <= 1'b1;
            byte_cnt_r <= '0;
            cks_r      <= 8'd0;
          end else begin
            state_r <= ST_HUNT;
          end
        end
        ST_PAYLOAD, ST_CHECK: begin
          if (stop_err_r || (!byte_done_r && (to_cnt_r == 32'(TO_LIMIT - 1)))) begin
            frame_err <= 1'b1;
            isbusy    <= 1'b0;
            state_r   <= ST_HUNT;
          end else if (byte_done_r) begin
            to_cnt_r <= 32'd0;
            if (state_r == ST_PAYLOAD) begin
              buf_r[byte_pos_s +: 8] <= rx_byte_r;
              cks_r                  <= cks_next(cks_r, rx_byte_r);
              if (byte_cnt_r == BW'(NB - 1)) begin
                state_r <= ST_CHECK;
              end else begin
                byte_cnt_r <= byte_cnt_r + BW'(1);
              end
            end else begin
              if (rx_byte_r == cks_r) begin
                pkt_data  <= buf_r;
                pkt_valid <= 1'b1;
              end else begin
                pkt_err   <= 1'b1;
              end
              isbusy  <= 1'b0;
              state_r <= ST_HUNT;
            end
          end else begin
            to_cnt_r <= to_cnt_r + 32'd1;
          end
        end
        default: begin
          state_r <= ST_HUNT;
          isbusy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_receive_packet.sv
// tb_receive_packet: directed bench for receive_packet using a short bit period.
module tb_receive_packet;

  localparam int CPB = 16;
  localparam int NW  = 10;

  logic              clk;
  logic              rst_n;
  logic              rx;
  logic [NW*32-1:0]  pkt_data;
  logic              pkt_valid, pkt_err, frame_err, isbusy;

  int n_cmp;
  int n_bad;
  int valid_cnt, err_cnt, frame_cnt, overlap_cnt, held_cnt;
  logic prev_v, prev_e, prev_f;

  logic [NW*32-1:0] pkt_a;
  logic [NW*32-1:0] pkt_b;

  receive_packet #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_err   (pkt_err),
    .frame_err (frame_err),
    .isbusy    (isbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts output pulses, overlaps and pulses held past one cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0; prev_e = 1'b0; prev_f = 1'b0;
    end else begin
      if (pkt_valid) valid_cnt++;
      if (pkt_err)   err_cnt++;
      if (frame_err) frame_cnt++;
      if ((int'(pkt_valid) + int'(pkt_err) + int'(frame_err)) > 1) overlap_cnt++;
      if ((prev_v && pkt_valid) || (prev_e && pkt_err) || (prev_f && frame_err)) held_cnt++;
      prev_v = pkt_valid; prev_e = pkt_err; prev_f = frame_err;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Payload bytes first..last, big-endian per word, word0 first
  task automatic send_bytes(input logic [NW*32-1:0] w, input int first, input int last);
    for (int b = first; b <= last; b++) begin
      send_byte(w[(b / 4) * 32 + (3 - (b % 4)) * 8 +: 8], 1'b1);
    end
  endtask

  task automatic send_packet(input logic [NW*32-1:0] w, input logic [7:0] cks);
    send_byte(8'hA5, 1'b1);
    send_bytes(w, 0, NW * 4 - 1);
    send_byte(cks, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_words(input string tag, input logic [NW*32-1:0] exp);
    for (int k = 0; k < NW; k++) begin
      chk_eq($sformatf("%s_w%0d", tag, k), pkt_data[k*32 +: 32], exp[k*32 +: 32]);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    valid_cnt = 0; err_cnt = 0; frame_cnt = 0; overlap_cnt = 0; held_cnt = 0;
    pkt_a = {32'h00000000, 32'h00005632, 32'h00008038, 32'h78766536, 32'h00002413,
             32'h00007764, 32'h00004245, 32'h00007689, 32'h00001254, 32'h00024543};
    pkt_b = pkt_a;
    pkt_b[31:0] = 32'hA5A5A5A5;
    rx = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk_eq("rst_valid", {31'd0, pkt_valid}, 32'd0);
    chk_eq("rst_err",   {31'd0, pkt_err},   32'd0);
    chk_eq("rst_frame", {31'd0, frame_err}, 32'd0);
    chk_eq("rst_busy",  {31'd0, isbusy},    32'd0);
    chk_eq("rst_data",  pkt_data[31:0],     32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: good packet, checksum 8'h1F
    send_byte(8'hA5, 1'b1);
    chk_eq("t1_busy_after_sync", {31'd0, isbusy}, 32'd1);
    send_bytes(pkt_a, 0, NW * 4 - 1);
    send_byte(8'h1F, 1'b1);
    repeat (4) @(negedge clk);
    chk_eq("t1_valid_cnt", valid_cnt, 32'd1);
    chk_eq("t1_err_cnt",   err_cnt,   32'd0);
    chk_eq("t1_frame_cnt", frame_cnt, 32'd0);
    chk_eq("t1_busy",      {31'd0, isbusy}, 32'd0);
    chk_words("t1", pkt_a);

    // 2: from reset, bad checksum -> pkt_err, data stays 0
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("t2_rst_clears", pkt_data[63:32], 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_packet(pkt_a, 8'h1E);
    chk_eq("t2_valid_cnt", valid_cnt, 32'd1);
    chk_eq("t2_err_cnt",   err_cnt,   32'd1);
    chk_eq("t2_data_w0",   pkt_data[31:0], 32'd0);
    chk_eq("t2_busy",      {31'd0, isbusy}, 32'd0);

    // 3: noise before sync, A5 as payload data, 100-cycle pause below timeout
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    chk_eq("t3_noise_busy", {31'd0, isbusy}, 32'd0);
    send_byte(8'hA5, 1'b1);
    send_bytes(pkt_b, 0, 19);
    repeat (100) @(negedge clk);
    send_bytes(pkt_b, 20, NW * 4 - 1);
    send_byte(8'h1B, 1'b1);
    repeat (4) @(negedge clk);
    chk_eq("t3_valid_cnt", valid_cnt, 32'd2);
    chk_eq("t3_err_cnt",   err_cnt,   32'd1);
    chk_eq("t3_frame_cnt", frame_cnt, 32'd0);
    chk_words("t3", pkt_b);

    // 4: stall after 17 payload bytes -> timeout abort, then good packet
    send_byte(8'hA5, 1'b1);
    send_bytes(pkt_a, 0, 16);
    repeat (200) @(negedge clk);
    chk_eq("t4_busy_before_to", {31'd0, isbusy}, 32'd1);
    chk_eq("t4_frame_before_to", frame_cnt, 32'd0);
    repeat (200) @(negedge clk);
    chk_eq("t4_frame_cnt", frame_cnt, 32'd1);
    chk_eq("t4_busy",      {31'd0, isbusy}, 32'd0);
    chk_eq("t4_valid_mid", valid_cnt, 32'd2);
    send_packet(pkt_a, 8'h1F);
    chk_eq("t4_valid_cnt", valid_cnt, 32'd3);
    chk_words("t4", pkt_a);

    // 5: stop bit low mid-payload -> frame_err, back to hunt
    send_byte(8'hA5, 1'b1);
    send_bytes(pkt_b, 0, 5);
    send_byte(8'h3C, 1'b0);
    repeat (2) @(negedge clk);
    chk_eq("t5_frame_cnt", frame_cnt, 32'd2);
    chk_eq("t5_busy",      {31'd0, isbusy}, 32'd0);
    send_packet(pkt_b, 8'h1B);
    chk_eq("t5_valid_cnt", valid_cnt, 32'd4);
    chk_eq("t5_err_cnt",   err_cnt,   32'd1);
    chk_words("t5", pkt_b);

    // 6: reset mid-payload clears outputs at once; next packet accepted
    send_byte(8'hA5, 1'b1);
    send_bytes(pkt_a, 0, 9);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    chk_eq("t6_busy_pre", {31'd0, isbusy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("t6_busy_rst", {31'd0, isbusy}, 32'd0);
    chk_eq("t6_data_rst", pkt_data[31:0], 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_packet(pkt_a, 8'h1F);
    chk_eq("t6_valid_cnt", valid_cnt, 32'd5);
    chk_eq("t6_frame_cnt", frame_cnt, 32'd2);
    chk_words("t6", pkt_a);

    chk_eq("overlap", overlap_cnt, 32'd0);
    chk_eq("held",    held_cnt,    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
